seg7_sequence_decoder: RTL and testbench
========================================

Name: seg7_sequence_decoder

Overview:
Receive-side companion to the letter-stepping 7-segment driver. It samples an 8-bit segment bus driven by another die or board, debounces it, and decodes each stable pattern into a 4-bit character code. It then checks the decoded stream against the fixed 14-step name sequence (marker, S,E,n,O,L,G,U,L,G,O,n,U,L) and reports lock, completion and error status. It sits behind the pad inputs and feeds status to the outputs or a host.

Parameters:
STABLE_CYCLES, 4, consecutive equal synchronized samples required before a pattern is accepted (legal range 2..15)

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
seg_in  input  8  segment bus, bit7=dp, bit6=a … bit0=g; asynchronous to clk
code_out  output  4  code of the last accepted pattern
code_valid  output  1  one-cycle pulse when code_out is updated
seq_pos  output  4  index (0..13) of the next expected sequence step
locked  output  1  high while the tracker is in TRACK
seq_done  output  1  one-cycle pulse when step 13 is matched
err_count  output  4  saturating count of sequence mismatches

Behaviour:
- Reset (async assert, sync release): all registers clear; code_out=0, code_valid=0, seq_pos=0, locked=0, seq_done=0, err_count=0, last-accepted pattern=8'h00, FSM=IDLE.
- Input path: 2-flop synchronizer on seg_in produces s2. A candidate register and counter track s2.
  - If s2 differs from the candidate: load the candidate and clear the counter.
  - Otherwise: increment the counter, saturating at STABLE_CYCLES-1.
- Accept: occurs when the counter reaches STABLE_CYCLES-1 and the candidate differs from the last-accepted pattern.
  - On accept: update last-accepted, update code_out, pulse code_valid.
  - Latency: seg_in changes before edge 1 and is held; code_valid is high during the cycle after edge STABLE_CYCLES+2 (edge 6 at default).
  - Pulses shorter than STABLE_CYCLES samples are never accepted.
  - Returning to the last-accepted pattern after a rejected glitch produces no pulse.
- Decode table (exact match, else code 15 = unknown):
  - 80→0 (marker), 5B→1 S, 4F→2 E, 15→3 n, 7E→4 O, 0E→5 L, 5F→6 G, 3E→7 U, 00→8 blank.
- Expected code at positions 0..13: 0,1,2,3,4,5,6,7,5,6,4,3,7,5.
- Tracker FSM acts only on accepted codes; blank (8) is ignored in all states.
  - IDLE, code 0 → TRACK, seq_pos=1. Any other code → stay in IDLE with no count.
  - TRACK, code == expected[seq_pos]:
    - If seq_pos==13: seq_pos=0 and seq_done pulses in the same cycle as the code_valid pulse.
    - Otherwise: seq_pos+1.
  - TRACK, mismatch: err_count+1, saturating at 15.
    - If the code is 0: resync to seq_pos=1, stay in TRACK.
    - Otherwise: go to IDLE, seq_pos=0.
- locked = (FSM==TRACK). err_count is cleared only by reset.
- Reset mid-pattern: all state is discarded. The first pattern after release is accepted only if it is non-zero and stable for STABLE_CYCLES samples.

Test Plan:
1. Reset, then drive the full 14-pattern sequence, each held 10 cycles → 14 code_valid pulses with codes 0,1,2,3,4,5,6,7,5,6,4,3,7,5; locked high from the marker on; a single seq_done with the final L; seq_pos=0; err_count=0.
2. Latency and glitch handling at default STABLE_CYCLES=4:
   - Change seg_in 00→5B just before edge 1 → code_valid high only in the cycle after edge 6.
   - A 3-cycle 4F glitch between two 5B holds → no pulse.
3. While tracking, after S drive 5F (G) instead of E → code 6 reported, err_count=1, locked=0, seq_pos=0. A later 80 → locked=1, seq_pos=1.
4. Mismatch with marker: after S,E drive 80 → err_count+1, locked stays 1, seq_pos=1.
5. Unknown and blank patterns:
   - Drive 0xFF → code 15 and an error if tracking.
   - Drive 00 between letters → code 8 and no state change.
   - Force 20 mismatches → err_count saturates at 15.
6. Assert rst_n asynchronously mid-hold → all outputs 0 immediately. Release with a stable 80 held → code_valid at the expected latency, locked=1.

Source files
------------

// File: rtl/seg7_sequence_decoder.sv
// rtl/seg7_sequence_decoder.sv - debounced 7-segment pattern decoder with name-sequence tracker
module seg7_sequence_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] seg_in,
  output logic [3:0] code_out,
  output logic       code_valid,
  output logic [3:0] seq_pos,
  output logic       locked,
  output logic       seq_done,
  output logic [3:0] err_count
);

  typedef enum logic {IDLE, TRACK} state_t;

  localparam logic [3:0] CNT_MAX = 4'(STABLE_CYCLES - 1);
  localparam logic [3:0] CODE_BLANK = 4'd8;
  localparam logic [3:0] LAST_POS = 4'd13;

  state_t     state, state_next;
  logic [7:0] s1, s2, cand, last;
  logic [3:0] cnt, cnt_next;
  logic       accept;
  logic [3:0] dec_code, exp_code;
  logic [3:0] pos_next, err_next;
  logic       done_next;

  // Counter saturates at CNT_MAX; accept fires on the edge the count reaches it.
  always_comb begin
    cnt_next = 4'd0;
    if (s2 == cand) begin
      cnt_next = (cnt == CNT_MAX) ? CNT_MAX : cnt + 4'd1;
    end
    accept = (s2 == cand) && (cnt_next == CNT_MAX) && (cand != last);
  end

  always_comb begin
    case (cand)
      8'h80:   dec_code = 4'd0;
      8'h5B:   dec_code = 4'd1;
      8'h4F:   dec_code = 4'd2;
      8'h15:   dec_code = 4'd3;
      8'h7E:   dec_code = 4'd4;
      8'h0E:   dec_code = 4'd5;
      8'h5F:   dec_code = 4'd6;
      8'h3E:   dec_code = 4'd7;
      8'h00:   dec_code = 4'd8;
      default: dec_code = 4'd15;
    endcase
  end

  // Marker, S, E, n, O, L, G, U, L, G, O, n, U, L
  always_comb begin
    case (seq_pos)
      4'd0:    exp_code = 4'd0;
      4'd1:    exp_code = 4'd1;
      4'd2:    exp_code = 4'd2;
      4'd3:    exp_code = 4'd3;
      4'd4:    exp_code = 4'd4;
      4'd5:    exp_code = 4'd5;
      4'd6:    exp_code = 4'd6;
      4'd7:    exp_code = 4'd7;
      4'd8:    exp_code = 4'd5;
      4'd9:    exp_code = 4'd6;
      4'd10:   exp_code = 4'd4;
      4'd11:   exp_code = 4'd3;
      4'd12:   exp_code = 4'd7;
      4'd13:   exp_code = 4'd5;
      default: exp_code = 4'd15;
    endcase
  end

  always_comb begin
    state_next = state;
    pos_next   = seq_pos;
    err_next   = err_count;
    done_next  = 1'b0;
    if (accept && dec_code != CODE_BLANK) begin
      case (state)
        IDLE: begin
          if (dec_code == 4'd0) begin
            state_next = TRACK;
            pos_next   = 4'd1;
          end
        end
        TRACK: begin
          if (dec_code == exp_code) begin
            if (seq_pos == LAST_POS) begin
              pos_next  = 4'd0;
              done_next = 1'b1;
            end else begin
              pos_next = seq_pos + 4'd1;
            end
          end else begin
            err_next = (err_count == 4'd15) ? 4'd15 : err_count + 4'd1;
            if (dec_code == 4'd0) begin
              pos_next = 4'd1;
            end else begin
              state_next = IDLE;
              pos_next   = 4'd0;
            end
          end
        end
        default: begin
          state_next = IDLE;
          pos_next   = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= 8'h00;
      s2         <= 8'h00;
      cand       <= 8'h00;
      cnt        <= 4'd0;
      last       <= 8'h00;
      code_out   <= 4'd0;
      code_valid <= 1'b0;
      state      <= IDLE;
      seq_pos    <= 4'd0;
      err_count  <= 4'd0;
      seq_done   <= 1'b0;
    end else begin
      s1         <= seg_in;
      s2         <= s1;
      cand       <= s2;
      cnt        <= cnt_next;
      code_valid <= accept;
      if (accept) begin
        last     <= cand;
        code_out <= dec_code;
      end
      state     <= state_next;
      seq_pos   <= pos_next;
      err_count <= err_next;
      seq_done  <= done_next;
    end
  end

  assign locked = (state == TRACK);

endmodule

// File: tb/tb_seg7_sequence_decoder.sv
// tb/tb_seg7_sequence_decoder.sv - vector table, corner sequences and random stimulus vs reference model
module tb_seg7_sequence_decoder;

  localparam int STABLE = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] seg_in;
  logic [3:0] code_out, seq_pos, err_count;
  logic       code_valid, locked, seq_done;

  int n_cmp = 0;
  int n_err = 0;

  seg7_sequence_decoder #(.STABLE_CYCLES(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .code_out(code_out),
    .code_valid(code_valid), .seq_pos(seq_pos), .locked(locked),
    .seq_done(seq_done), .err_count(err_count)
  );

  always #5 clk = ~clk;

  logic [7:0] pat_of [9] = '{8'h80, 8'h5B, 8'h4F, 8'h15, 8'h7E, 8'h0E, 8'h5F, 8'h3E, 8'h00};
  int         exp_seq[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 5, 6, 4, 3, 7, 5};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [7:0] p);
    for (int i = 0; i < 9; i++) if (pat_of[i] == p) return i;
    return 15;
  endfunction

  // Reference model: a synchronizer queue, an unbounded run length of equal samples,
  // and the sequence rules applied directly to the decoded code.
  logic [7:0] m_sync[2];
  logic [7:0] run_val, m_last;
  int         run_len, m_pos, m_err, mc;
  logic [3:0] m_code;
  logic       m_valid, m_done, m_trk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_sync[0] = 8'h00; m_sync[1] = 8'h00;
      run_val = 8'h00; run_len = 1; m_last = 8'h00;
      m_code = 4'd0; m_valid = 1'b0; m_done = 1'b0; m_trk = 1'b0; m_pos = 0; m_err = 0;
    end else begin
      m_valid = 1'b0;
      m_done  = 1'b0;
      if (m_sync[1] == run_val) run_len++;
      else begin
        run_val = m_sync[1];
        run_len = 1;
      end
      if (run_len >= STABLE && run_val != m_last) begin
        m_last  = run_val;
        mc      = decode(run_val);
        m_code  = 4'(mc);
        m_valid = 1'b1;
        if (mc != 8) begin
          if (!m_trk) begin
            if (mc == 0) begin m_trk = 1'b1; m_pos = 1; end
          end else if (mc == exp_seq[m_pos]) begin
            if (m_pos == 13) begin m_pos = 0; m_done = 1'b1; end
            else m_pos++;
          end else begin
            if (m_err < 15) m_err++;
            if (mc == 0) m_pos = 1;
            else begin m_trk = 1'b0; m_pos = 0; end
          end
        end
      end
      m_sync[1] = m_sync[0];
      m_sync[0] = seg_in;
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1)
      chk("model", {code_out, code_valid, seq_pos, locked, seq_done, err_count},
          {m_code, m_valid, 4'(m_pos), m_trk, m_done, 4'(m_err)});
  end

  typedef struct {
    logic [7:0] seg;
    logic [3:0] code;
    logic [3:0] pos;
    logic       lck;
    logic [3:0] err;
  } vec_t;

  vec_t tbl[26];
  int   dones;

  task automatic apply_vec(input vec_t v, input int idx);
    int pulses = 0;
    logic [3:0] got = 4'hx;
    @(negedge clk);
    seg_in = v.seg;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (code_valid) begin
        pulses++;
        got = code_out;
        if (seq_done) dones++;
      end
    end
    chk($sformatf("vec%0d_pulses", idx), pulses, 1);
    chk($sformatf("vec%0d_code", idx), got, v.code);
    chk($sformatf("vec%0d_pos", idx), seq_pos, v.pos);
    chk($sformatf("vec%0d_locked", idx), locked, v.lck);
    chk($sformatf("vec%0d_err", idx), err_count, v.err);
  endtask

  task automatic hold(input logic [7:0] p, input int n);
    @(negedge clk);
    seg_in = p;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int pulses;
    // sequence, wrong letter, marker resync, blank and unknown
    tbl[0]  = '{8'h80, 4'd0, 4'd1,  1'b1, 4'd0};
    tbl[1]  = '{8'h5B, 4'd1, 4'd2,  1'b1, 4'd0};
    tbl[2]  = '{8'h4F, 4'd2, 4'd3,  1'b1, 4'd0};
    tbl[3]  = '{8'h15, 4'd3, 4'd4,  1'b1, 4'd0};
    tbl[4]  = '{8'h7E, 4'd4, 4'd5,  1'b1, 4'd0};
    tbl[5]  = '{8'h0E, 4'd5, 4'd6,  1'b1, 4'd0};
    tbl[6]  = '{8'h5F, 4'd6, 4'd7,  1'b1, 4'd0};
    tbl[7]  = '{8'h3E, 4'd7, 4'd8,  1'b1, 4'd0};
    tbl[8]  = '{8'h0E, 4'd5, 4'd9,  1'b1, 4'd0};
    tbl[9]  = '{8'h5F, 4'd6, 4'd10, 1'b1, 4'd0};
    tbl[10] = '{8'h7E, 4'd4, 4'd11, 1'b1, 4'd0};
    tbl[11] = '{8'h15, 4'd3, 4'd12, 1'b1, 4'd0};
    tbl[12] = '{8'h3E, 4'd7, 4'd13, 1'b1, 4'd0};
    tbl[13] = '{8'h0E, 4'd5, 4'd0,  1'b1, 4'd0};
    tbl[14] = '{8'h80, 4'd0, 4'd1,  1'b1, 4'd0};
    tbl[15] = '{8'h5B, 4'd1, 4'd2,  1'b1, 4'd0};
    tbl[16] = '{8'h5F, 4'd6, 4'd0,  1'b0, 4'd1};
    tbl[17] = '{8'h80, 4'd0, 4'd1,  1'b1, 4'd1};
    tbl[18] = '{8'h5B, 4'd1, 4'd2,  1'b1, 4'd1};
    tbl[19] = '{8'h4F, 4'd2, 4'd3,  1'b1, 4'd1};
    tbl[20] = '{8'h80, 4'd0, 4'd1,  1'b1, 4'd2};
    tbl[21] = '{8'h00, 4'd8, 4'd1,  1'b1, 4'd2};
    tbl[22] = '{8'h5B, 4'd1, 4'd2,  1'b1, 4'd2};
    tbl[23] = '{8'h00, 4'd8, 4'd2,  1'b1, 4'd2};
    tbl[24] = '{8'hFF, 4'd15, 4'd0, 1'b0, 4'd3};
    tbl[25] = '{8'h00, 4'd8, 4'd0,  1'b0, 4'd3};

    rst_n  = 1'b0;
    seg_in = 8'h00;
    #1;
    chk("reset_outputs", {code_out, code_valid, seq_pos, locked, seq_done, err_count}, 15'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // 00 -> 5B just before edge 1: pulse only after edge STABLE+2
    seg_in = 8'h5B;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("latency_edge%0d", k), code_valid, (k == STABLE + 2));
      if (k == STABLE + 2) chk("latency_code", code_out, 4'd1);
    end

    // short 4F glitch between two 5B holds
    pulses = 0;
    seg_in = 8'h4F;
    repeat (STABLE - 1) begin @(negedge clk); if (code_valid) pulses++; end
    seg_in = 8'h5B;
    repeat (12) begin @(negedge clk); if (code_valid) pulses++; end
    chk("glitch_pulses", pulses, 0);

    dones = 0;
    for (int i = 0; i < 26; i++) begin
      apply_vec(tbl[i], i);
      if (i == 13) chk("seq_done_count", dones, 1);
    end

    for (int i = 0; i < 20; i++) begin
      hold(8'h80, 8);
      hold(8'hFF, 8);
    end
    chk("err_saturated", err_count, 4'd15);

    // async reset in the middle of a hold
    hold(8'h7E, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {code_out, code_valid, seq_pos, locked, seq_done, err_count}, 15'd0);
    @(negedge clk);
    seg_in = 8'h80;
    rst_n  = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk($sformatf("post_reset_edge%0d", k), code_valid, (k == STABLE + 2));
    end
    chk("post_reset_locked", locked, 1'b1);
    chk("post_reset_pos", seq_pos, 4'd1);

    // random: half the time drive the next expected letter so locks and completions occur
    for (int s = 0; s < 400; s++) begin
      int r;
      logic [7:0] p;
      r = $urandom_range(0, 9);
      if (r < 5) p = pat_of[exp_seq[m_pos]];
      else if (r < 8) p = pat_of[$urandom_range(0, 8)];
      else if (r == 8) p = 8'hFF;
      else p = 8'($urandom);
      hold(p, $urandom_range(1, 9));
    end
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
